// File: rtl/icache_arbiter_pkg.sv
// Shared types for the instruction-cache arbiter: request/response record,
// access types, FSM state encoding and the access_id width.
package icache_arbiter_pkg;

   localparam int MAX_REQ       = 8;
   localparam int ARB_IDX_WIDTH = $clog2(MAX_REQ);
   localparam int ADDR_W        = 32;
   localparam int DATA_W        = 64;

   typedef enum logic [1:0] {
      ACC_FETCH    = 2'd0,
      ACC_PREFETCH = 2'd1,
      ACC_INVAL    = 2'd2
   } access_type_e;

   // Same record carries requests towards the icache and responses back.
   typedef struct packed {
      logic                     vld;
      access_type_e             acc_type;
      logic [ARB_IDX_WIDTH-1:0] access_id;
      logic [ADDR_W-1:0]        addr;
      logic [DATA_W-1:0]        data;
   } request_t;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ISSUE    = 2'd1,
      ST_WAIT_RSP = 2'd2
   } arb_state_e;

endpackage

// File: rtl/icache_arbiter_rr_arbiter.sv
// Combinational round-robin pick: the first set request at or after ptr_i
// (wrapping) wins. Produces a one-hot grant, its index and an any-grant flag.
module rr_arbiter
   import icache_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IW      = ARB_IDX_WIDTH
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IW-1:0]      ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IW-1:0]      idx_o,
   output logic               vld_o
);

   // Scan priority positions k = 0.. from the pointer; first hit wins.
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      vld_o = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         for (int j = 0; j < NUM_REQ; j++) begin
            if (!vld_o && req_i[j] && (((int'(ptr_i) + k) % NUM_REQ) == j)) begin
               vld_o    = 1'b1;
               gnt_o[j] = 1'b1;
               idx_o    = IW'(j);
            end
         end
      end
   end

endmodule

// File: rtl/icache_arbiter.sv
// Shares one icache port among NUM_REQ ifetch units. Each requester owns a
// one-entry pending slot; a single access is outstanding at a time and the
// response is steered back by access_id with zero latency.
// Optional build macro ICACHE_ARB_PERF_EN adds per-requester grant/drop counters.
module icache_arbiter
   import icache_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  request_t [NUM_REQ-1:0] req_in,
   output logic     [NUM_REQ-1:0] req_busy,
   output request_t [NUM_REQ-1:0] rsp_out,
   output request_t               icache_req,
   input  logic                   icache_busy,
   input  request_t               icache_rsp
`ifdef ICACHE_ARB_PERF_EN
   ,
   output logic [NUM_REQ-1:0][31:0] grant_cnt,
   output logic [NUM_REQ-1:0][15:0] drop_cnt
`endif
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   arb_state_e             state_q, state_d;
   request_t [NUM_REQ-1:0] slot_q, slot_d;
   logic     [NUM_REQ-1:0] slot_vld_q, slot_vld_d;
   logic     [IW-1:0]      rr_ptr_q, rr_ptr_d;
   logic     [NUM_REQ-1:0] gnt_q, gnt_d;
   request_t               icache_req_q, icache_req_d;

   logic [NUM_REQ-1:0] arb_gnt;
   logic [IW-1:0]      arb_idx;
   logic               arb_vld;
   logic               grant_fire;

   rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr (
      .req_i (slot_vld_q),
      .ptr_i (rr_ptr_q),
      .gnt_o (arb_gnt),
      .idx_o (arb_idx),
      .vld_o (arb_vld)
   );

   // Grant decision is taken in IDLE only; busy is not looked at afterwards.
   assign grant_fire = (state_q == ST_IDLE) && arb_vld && !icache_busy;

   // Slot fill/clear: the issued slot frees when leaving ISSUE; a request
   // hitting a full slot (including that ISSUE cycle) is dropped.
   always_comb begin
      slot_d     = slot_q;
      slot_vld_d = slot_vld_q;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (state_q == ST_ISSUE && gnt_q[i]) begin
            slot_vld_d[i] = 1'b0;
         end else if (req_in[i].vld && !slot_vld_q[i]) begin
            slot_vld_d[i] = 1'b1;
            slot_d[i]     = req_in[i];
         end
      end
   end

   // FSM next state; the icache request is registered at the grant edge so
   // it is valid for exactly the ISSUE cycle.
   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      gnt_d        = gnt_q;
      icache_req_d = '0;
      case (state_q)
         ST_IDLE: begin
            if (grant_fire) begin
               state_d                = ST_ISSUE;
               gnt_d                  = arb_gnt;
               rr_ptr_d               = (arb_idx == IW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
               icache_req_d           = slot_q[arb_idx];
               icache_req_d.vld       = 1'b1;
               icache_req_d.access_id = ARB_IDX_WIDTH'(arb_idx);
            end
         end
         ST_ISSUE:    state_d = ST_WAIT_RSP;
         ST_WAIT_RSP: if (icache_rsp.vld) state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   // Zero-latency response steering; out-of-range ids and stray responses
   // outside WAIT_RSP are swallowed.
   always_comb begin
      rsp_out = '0;
      if (!reset && state_q == ST_WAIT_RSP && icache_rsp.vld &&
          int'(icache_rsp.access_id) < NUM_REQ)
         rsp_out[icache_rsp.access_id[IW-1:0]] = icache_rsp;
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         slot_q       <= '0;
         slot_vld_q   <= '0;
         rr_ptr_q     <= '0;
         gnt_q        <= '0;
         icache_req_q <= '0;
      end else begin
         state_q      <= state_d;
         slot_q       <= slot_d;
         slot_vld_q   <= slot_vld_d;
         rr_ptr_q     <= rr_ptr_d;
         gnt_q        <= gnt_d;
         icache_req_q <= icache_req_d;
      end
   end

   assign req_busy   = slot_vld_q;
   assign icache_req = icache_req_q;

`ifdef ICACHE_ARB_PERF_EN
   logic [NUM_REQ-1:0][31:0] grant_cnt_q;
   logic [NUM_REQ-1:0][15:0] drop_cnt_q;

   // Grant counters wrap; drop counters saturate.
   always_ff @(posedge clk) begin
      if (reset) begin
         grant_cnt_q <= '0;
         drop_cnt_q  <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_fire && arb_gnt[i])
               grant_cnt_q[i] <= grant_cnt_q[i] + 32'd1;
            if (req_in[i].vld && slot_vld_q[i] && drop_cnt_q[i] != 16'hFFFF)
               drop_cnt_q[i] <= drop_cnt_q[i] + 16'd1;
         end
      end
   end

   assign grant_cnt = grant_cnt_q;
   assign drop_cnt  = drop_cnt_q;
`endif

endmodule
